// File: rtl/ahb_interconnect_prio_arbiter.sv
// N-master priority arbiter for the AHB-lite master-side address mux.
// Highest priority wins, ties rotate round-robin, locked transfers and hready boundaries are honoured.
module ahb_interconnect_prio_arbiter #(
    parameter int N_MASTER       = 4,
    parameter int PRIO_W         = 2,
    parameter int HOLD_MAX       = 16,
    parameter int DEFAULT_MASTER = 0,
    localparam int ID_W          = (N_MASTER > 1) ? $clog2(N_MASTER) : 1,
    localparam int HOLD_W        = $clog2(HOLD_MAX)
) (
    input  logic                       HCLK,
    input  logic                       HRESET,
    input  logic [N_MASTER-1:0]        req,
    input  logic [N_MASTER-1:0]        lock,
    input  logic [N_MASTER*PRIO_W-1:0] prio,
    input  logic                       hready,
    output logic [N_MASTER-1:0]        grant,
    output logic [ID_W-1:0]            grant_id,
    output logic                       grant_valid,
    output logic                       grant_chg
);

    typedef enum logic [1:0] {
        PARK = 2'd0,
        OWN  = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam logic [ID_W-1:0]     DEF_ID   = ID_W'(DEFAULT_MASTER);
    localparam logic [HOLD_W-1:0]   HOLD_TOP = HOLD_W'(HOLD_MAX - 1);
    localparam logic [N_MASTER-1:0] ONE_HOT0 = N_MASTER'(1);

    state_t                state_reg, state_next;
    logic [N_MASTER-1:0]   grant_reg;
    logic [ID_W-1:0]       grant_id_reg, grant_id_next;
    logic                  grant_valid_reg, grant_valid_next;
    logic                  grant_chg_reg, grant_chg_next;
    logic [HOLD_W-1:0]     hold_cnt_reg, hold_cnt_next;
    logic [ID_W-1:0]       rr_ptr_reg, rr_ptr_next;

    logic [PRIO_W-1:0]     prio_arr [N_MASTER];
    logic                  win_valid;
    logic [ID_W-1:0]       win_id;
    logic [PRIO_W-1:0]     win_prio;
    logic [ID_W-1:0]       scan_idx;

    logic                  owner_req, owner_lock;
    logic [PRIO_W-1:0]     owner_prio;
    logic                  take_winner, go_park, keep_inc;

    generate
        for (genvar gi = 0; gi < N_MASTER; gi++) begin : g_prio
            assign prio_arr[gi] = prio[gi*PRIO_W +: PRIO_W];
        end
    endgenerate

    // Scan from rr_ptr+1 upward; only a strictly greater priority replaces the
    // current best, so the first equal-priority master in rotation order wins.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        win_prio  = '0;
        scan_idx  = '0;
        for (int k = 1; k <= N_MASTER; k++) begin
            scan_idx = ID_W'((int'(rr_ptr_reg) + k) % N_MASTER);
            if (req[scan_idx] && (!win_valid || (prio_arr[scan_idx] > win_prio))) begin
                win_valid = 1'b1;
                win_id    = scan_idx;
                win_prio  = prio_arr[scan_idx];
            end
        end
    end

    assign owner_req  = req[grant_id_reg];
    assign owner_lock = lock[grant_id_reg];
    assign owner_prio = prio_arr[grant_id_reg];

    always_comb begin
        take_winner = 1'b0;
        go_park     = 1'b0;
        keep_inc    = 1'b0;
        state_next  = state_reg;
        case (state_reg)
            PARK: begin
                take_winner = win_valid;
            end
            OWN, LOCK: begin
                if (state_reg == LOCK && owner_req && owner_lock) begin
                    state_next = LOCK;
                end else if (!owner_req) begin
                    take_winner = win_valid;
                    go_park     = !win_valid;
                end else if (owner_lock) begin
                    state_next = LOCK;
                end else if (win_prio > owner_prio) begin
                    take_winner = 1'b1;
                end else if (hold_cnt_reg == HOLD_TOP && win_id != grant_id_reg) begin
                    // rr_ptr equals the owner here, so a differing winner is an equal-prio peer
                    take_winner = 1'b1;
                end else begin
                    state_next = OWN;
                    keep_inc   = 1'b1;
                end
            end
            default: begin
                go_park = 1'b1;
            end
        endcase
    end

    always_comb begin
        grant_id_next    = grant_id_reg;
        grant_valid_next = grant_valid_reg;
        grant_chg_next   = 1'b0;
        hold_cnt_next    = hold_cnt_reg;
        rr_ptr_next      = rr_ptr_reg;
        if (take_winner) begin
            grant_id_next    = win_id;
            grant_valid_next = 1'b1;
            grant_chg_next   = 1'b1;
            hold_cnt_next    = '0;
            rr_ptr_next      = win_id;
        end else if (go_park) begin
            grant_id_next    = DEF_ID;
            grant_valid_next = 1'b0;
            grant_chg_next   = (grant_id_reg != DEF_ID);
            hold_cnt_next    = '0;
        end else if (keep_inc && hold_cnt_reg != HOLD_TOP) begin
            hold_cnt_next    = hold_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_reg       <= PARK;
            grant_reg       <= ONE_HOT0 << DEF_ID;
            grant_id_reg    <= DEF_ID;
            grant_valid_reg <= 1'b0;
            grant_chg_reg   <= 1'b0;
            hold_cnt_reg    <= '0;
            rr_ptr_reg      <= DEF_ID;
        end else if (hready) begin
            state_reg       <= take_winner ? OWN : (go_park ? PARK : state_next);
            grant_reg       <= ONE_HOT0 << grant_id_next;
            grant_id_reg    <= grant_id_next;
            grant_valid_reg <= grant_valid_next;
            grant_chg_reg   <= grant_chg_next;
            hold_cnt_reg    <= hold_cnt_next;
            rr_ptr_reg      <= rr_ptr_next;
        end else begin
            // the change pulse is a single cycle even if the bus stalls right after
            grant_chg_reg   <= 1'b0;
        end
    end

    assign grant       = grant_reg;
    assign grant_id    = grant_id_reg;
    assign grant_valid = grant_valid_reg;
    assign grant_chg   = grant_chg_reg;

endmodule

// File: tb/tb_ahb_interconnect_prio_arbiter.sv
// Directed bench for ahb_interconnect_prio_arbiter: 4 masters, 2-bit priorities, HOLD_MAX=4.
module tb_ahb_interconnect_prio_arbiter;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic [3:0] req;
    logic [3:0] lock;
    logic [7:0] prio;
    logic       hready;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       grant_valid;
    logic       grant_chg;

    int total = 0;
    int bad   = 0;

    ahb_interconnect_prio_arbiter #(
        .N_MASTER(4), .PRIO_W(2), .HOLD_MAX(4), .DEFAULT_MASTER(0)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .req(req), .lock(lock), .prio(prio),
        .hready(hready), .grant(grant), .grant_id(grant_id),
        .grant_valid(grant_valid), .grant_chg(grant_chg)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("chk %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        HRESET = 1'b1; req = '0; lock = '0; prio = '0; hready = 1'b1;
        tick(); tick();
        HRESET = 1'b0;

        // reset state
        chk("rst_grant", 32'(grant), 32'h1);
        chk("rst_id",    32'(grant_id), 32'h0);
        chk("rst_valid", 32'(grant_valid), 32'h0);
        chk("rst_chg",   32'(grant_chg), 32'h0);
        chk("rst_hold",  32'(dut.hold_cnt_reg), 32'h0);

        // parked with no requests
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("park_grant", 32'(grant), 32'h1);
            chk("park_valid", 32'(grant_valid), 32'h0);
        end

        // prio m3..m0 = 3,1,1,0; tie m1/m2 resolved from rr_ptr+1 = m1
        prio = {2'd3, 2'd1, 2'd1, 2'd0};
        req  = 4'b0110;
        tick();
        chk("t2_grant", 32'(grant), 32'h2);
        chk("t2_id",    32'(grant_id), 32'h1);
        chk("t2_valid", 32'(grant_valid), 32'h1);
        chk("t2_chg",   32'(grant_chg), 32'h1);
        tick();
        chk("t2_keep",  32'(grant), 32'h2);
        chk("t2_chg0",  32'(grant_chg), 32'h0);
        req = 4'b1110;
        tick();
        chk("t2_preempt", 32'(grant), 32'h8);
        chk("t2_pid",     32'(grant_id), 32'h3);
        chk("t2_pchg",    32'(grant_chg), 32'h1);
        tick();
        chk("t2_hold3",   32'(grant), 32'h8);
        chk("t2_pchg0",   32'(grant_chg), 32'h0);

        // m1,m2 both prio 2: rotate every HOLD_MAX=4 cycles
        prio = {2'd0, 2'd2, 2'd2, 2'd0};
        req  = 4'b0110;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("t3_grant", 32'(grant), ((i / 4) % 2 == 0) ? 32'h2 : 32'h4);
            chk("t3_chg",   32'(grant_chg), (i % 4 == 0) ? 32'h1 : 32'h0);
        end

        // m0 owns and locks; higher-prio m3 waits for the lock to drop
        prio = '0;
        req  = 4'b0001;
        lock = 4'b0001;
        tick();
        chk("t4_own",   32'(grant), 32'h1);
        chk("t4_valid", 32'(grant_valid), 32'h1);
        chk("t4_chg",   32'(grant_chg), 32'h1);
        tick();
        chk("t4_lock",  32'(grant), 32'h1);
        prio = {2'd3, 2'd0, 2'd0, 2'd0};
        req  = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_locked", 32'(grant), 32'h1);
        end
        lock = 4'b0000;
        tick();
        chk("t4_m3",     32'(grant), 32'h8);
        chk("t4_m3chg",  32'(grant_chg), 32'h1);

        // stall: higher-prio request arrives while hready=0
        hready = 1'b0;
        tick();
        prio = {2'd1, 2'd0, 2'd3, 2'd0};
        req  = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_frozen", 32'(grant), 32'h8);
            chk("t5_fid",    32'(grant_id), 32'h3);
        end
        hready = 1'b1;
        tick();
        chk("t5_switch", 32'(grant), 32'h2);
        chk("t5_chg",    32'(grant_chg), 32'h1);

        // m2 owns a few cycles, locks, then reset mid-lock
        prio = '0;
        req  = 4'b0100;
        tick();
        chk("t6_own", 32'(grant), 32'h4);
        tick(); tick();
        lock = 4'b0100;
        tick();
        chk("t6_lock", 32'(grant), 32'h4);
        chk("t6_hold", 32'(dut.hold_cnt_reg), 32'h2);
        HRESET = 1'b1;
        tick();
        chk("t6_grant", 32'(grant), 32'h1);
        chk("t6_id",    32'(grant_id), 32'h0);
        chk("t6_valid", 32'(grant_valid), 32'h0);
        chk("t6_rhold", 32'(dut.hold_cnt_reg), 32'h0);
        HRESET = 1'b0;
        req  = '0;
        lock = '0;
        tick();
        chk("t6_park",  32'(grant), 32'h1);
        chk("t6_pval",  32'(grant_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
